// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional: define ID_EX_STALL_COUNT_EN to add stall/bubble counters.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_valid,
  input  logic [AW-1:0]   RS1_ID,
  input  logic [AW-1:0]   RS2_ID,
  input  logic [AW-1:0]   RD_ID,
  input  logic            uses_rs2_ID,
  input  logic            regwrite_ID,
  input  logic            memread_ID,
  input  logic            memwrite_ID,
  input  logic            memtoreg_ID,
  input  logic            alusrc_ID,
  input  logic [1:0]      aluop_ID,
  input  logic [XLEN-1:0] rdata1_ID,
  input  logic [XLEN-1:0] rdata2_ID,
  input  logic [XLEN-1:0] imm_ID,
  input  logic [XLEN-1:0] pc_ID,
  input  logic            flush,
  input  logic            hold,
  output logic [AW-1:0]   RS1_ID_EX,
  output logic [AW-1:0]   RS2_ID_EX,
  output logic [AW-1:0]   RD_ID_EX,
  output logic            regwrite_ID_EX,
  output logic            memread_ID_EX,
  output logic            memwrite_ID_EX,
  output logic            memtoreg_ID_EX,
  output logic            alusrc_ID_EX,
  output logic            valid_ID_EX,
  output logic [1:0]      aluop_ID_EX,
  output logic [XLEN-1:0] rdata1_ID_EX,
  output logic [XLEN-1:0] rdata2_ID_EX,
  output logic [XLEN-1:0] imm_ID_EX,
  output logic [XLEN-1:0] pc_ID_EX,
`ifdef ID_EX_STALL_COUNT_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt,
`endif
  output logic            PC_write,
  output logic            IF_ID_write,
  output logic            load_use_stall
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic [1:0]      aluop;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } id_ex_t;

  id_ex_t r_q;
  id_ex_t w_in;
  logic   w_hz;
  logic   w_bubble;

  // Controls of an empty decode slot are gated so it behaves as a bubble.
  always_comb begin
    w_in          = '0;
    w_in.valid    = ID_valid;
    w_in.regwrite = regwrite_ID & ID_valid;
    w_in.memread  = memread_ID & ID_valid;
    w_in.memwrite = memwrite_ID & ID_valid;
    w_in.memtoreg = memtoreg_ID & ID_valid;
    w_in.alusrc   = alusrc_ID & ID_valid;
    w_in.aluop    = ID_valid ? aluop_ID : 2'b00;
    w_in.rs1      = RS1_ID;
    w_in.rs2      = RS2_ID;
    w_in.rd       = RD_ID;
    w_in.rdata1   = rdata1_ID;
    w_in.rdata2   = rdata2_ID;
    w_in.imm      = imm_ID;
    w_in.pc       = pc_ID;
  end

  assign w_hz = r_q.valid & r_q.memread & (r_q.rd != '0) & ID_valid &
                ((r_q.rd == RS1_ID) |
                 (uses_rs2_ID & (r_q.rd == RS2_ID)));

  assign load_use_stall = w_hz & ~flush;
  assign PC_write       = ~(load_use_stall | hold);
  assign IF_ID_write    = ~(load_use_stall | hold);
  assign w_bubble       = flush | load_use_stall;

  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else if (!hold)
      r_q <= w_bubble ? '0 : w_in;
  end

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!hold) begin
      if (load_use_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_bubble && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

  assign valid_ID_EX    = r_q.valid;
  assign regwrite_ID_EX = r_q.regwrite;
  assign memread_ID_EX  = r_q.memread;
  assign memwrite_ID_EX = r_q.memwrite;
  assign memtoreg_ID_EX = r_q.memtoreg;
  assign alusrc_ID_EX   = r_q.alusrc;
  assign aluop_ID_EX    = r_q.aluop;
  assign RS1_ID_EX      = r_q.rs1;
  assign RS2_ID_EX      = r_q.rs2;
  assign RD_ID_EX       = r_q.rd;
  assign rdata1_ID_EX   = r_q.rdata1;
  assign rdata2_ID_EX   = r_q.rdata2;
  assign imm_ID_EX      = r_q.imm;
  assign pc_ID_EX       = r_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction stream,
// expected ID/EX state and hazard outputs queued and checked by a monitor.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_valid;
  logic [4:0]  RS1_ID, RS2_ID, RD_ID;
  logic        uses_rs2_ID;
  logic        regwrite_ID, memread_ID, memwrite_ID;
  logic        memtoreg_ID, alusrc_ID;
  logic [1:0]  aluop_ID;
  logic [31:0] rdata1_ID, rdata2_ID, imm_ID, pc_ID;
  logic        flush, hold;
  logic [4:0]  RS1_ID_EX, RS2_ID_EX, RD_ID_EX;
  logic        regwrite_ID_EX, memread_ID_EX, memwrite_ID_EX;
  logic        memtoreg_ID_EX, alusrc_ID_EX, valid_ID_EX;
  logic [1:0]  aluop_ID_EX;
  logic [31:0] rdata1_ID_EX, rdata2_ID_EX, imm_ID_EX, pc_ID_EX;
  logic        PC_write, IF_ID_write, load_use_stall;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .ID_valid(ID_valid),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
    .uses_rs2_ID(uses_rs2_ID),
    .regwrite_ID(regwrite_ID), .memread_ID(memread_ID),
    .memwrite_ID(memwrite_ID), .memtoreg_ID(memtoreg_ID),
    .alusrc_ID(alusrc_ID), .aluop_ID(aluop_ID),
    .rdata1_ID(rdata1_ID), .rdata2_ID(rdata2_ID),
    .imm_ID(imm_ID), .pc_ID(pc_ID),
    .flush(flush), .hold(hold),
    .RS1_ID_EX(RS1_ID_EX), .RS2_ID_EX(RS2_ID_EX), .RD_ID_EX(RD_ID_EX),
    .regwrite_ID_EX(regwrite_ID_EX), .memread_ID_EX(memread_ID_EX),
    .memwrite_ID_EX(memwrite_ID_EX), .memtoreg_ID_EX(memtoreg_ID_EX),
    .alusrc_ID_EX(alusrc_ID_EX), .valid_ID_EX(valid_ID_EX),
    .aluop_ID_EX(aluop_ID_EX),
    .rdata1_ID_EX(rdata1_ID_EX), .rdata2_ID_EX(rdata2_ID_EX),
    .imm_ID_EX(imm_ID_EX), .pc_ID_EX(pc_ID_EX),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .load_use_stall(load_use_stall)
  );

  typedef struct packed {
    logic        v, u2, rw, mr, mw, mt, as;
    logic [1:0]  aop;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } in_t;

  typedef struct packed {
    logic        valid, regwrite, memread, memwrite, memtoreg, alusrc;
    logic [1:0]  aluop;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } st_t;

  typedef struct {
    string name;
    st_t   regs;
    logic  stall;
    logic  pcw;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic in_t ins(logic v, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic u2, logic rw,
                              logic mr, logic mw, logic mt, logic as,
                              logic [1:0] aop, logic [31:0] d1,
                              logic [31:0] d2, logic [31:0] imm,
                              logic [31:0] pc);
    in_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u2 = u2;
    r.rw = rw; r.mr = mr; r.mw = mw; r.mt = mt; r.as = as;
    r.aop = aop; r.d1 = d1; r.d2 = d2; r.imm = imm; r.pc = pc;
    return r;
  endfunction

  // State the register should hold after a normal capture of i.
  function automatic st_t cap(in_t i);
    st_t s;
    s.valid = i.v;
    s.regwrite = i.rw & i.v;
    s.memread = i.mr & i.v;
    s.memwrite = i.mw & i.v;
    s.memtoreg = i.mt & i.v;
    s.alusrc = i.as & i.v;
    s.aluop = i.v ? i.aop : 2'b00;
    s.rs1 = i.rs1; s.rs2 = i.rs2; s.rd = i.rd;
    s.d1 = i.d1; s.d2 = i.d2; s.imm = i.imm; s.pc = i.pc;
    return s;
  endfunction

  task automatic drive(in_t i, logic r, logic f, logic h);
    rst = r; flush = f; hold = h;
    ID_valid = i.v; RS1_ID = i.rs1; RS2_ID = i.rs2; RD_ID = i.rd;
    uses_rs2_ID = i.u2; regwrite_ID = i.rw; memread_ID = i.mr;
    memwrite_ID = i.mw; memtoreg_ID = i.mt; alusrc_ID = i.as;
    aluop_ID = i.aop; rdata1_ID = i.d1; rdata2_ID = i.d2;
    imm_ID = i.imm; pc_ID = i.pc;
  endtask

  // Apply inputs just after a rising edge; expect regs from the prior edge.
  task automatic step(string nm, in_t i, logic r, logic f, logic h,
                      st_t er, logic es, logic ep);
    chk_t c;
    @(posedge clk);
    #1;
    drive(i, r, f, h);
    c.name = nm; c.regs = er; c.stall = es; c.pcw = ep;
    q.push_back(c);
  endtask

  function automatic in_t rnd();
    return ins(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 2'($urandom), $urandom,
               $urandom, $urandom, $urandom);
  endfunction

  // Monitor: compare at the falling edge whenever an expectation waits.
  initial begin
    chk_t c;
    st_t  a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        c = q.pop_front();
        a = {valid_ID_EX, regwrite_ID_EX, memread_ID_EX, memwrite_ID_EX,
             memtoreg_ID_EX, alusrc_ID_EX, aluop_ID_EX, RS1_ID_EX,
             RS2_ID_EX, RD_ID_EX, rdata1_ID_EX, rdata2_ID_EX,
             imm_ID_EX, pc_ID_EX};
        checks++;
        if (a === c.regs) passes++;
        else $display("FAIL %s regs: got %h want %h", c.name, a, c.regs);
        checks++;
        if ({load_use_stall, PC_write, IF_ID_write} ===
            {c.stall, c.pcw, c.pcw}) passes++;
        else $display("FAIL %s ctl: got stall=%b pcw=%b ifw=%b want %b %b %b",
                      c.name, load_use_stall, PC_write, IF_ID_write,
                      c.stall, c.pcw, c.pcw);
      end
    end
  end

  initial begin
    st_t bub = '0;
    in_t A  = ins(1, 1, 0, 5, 0, 1, 1, 0, 1, 1, 0, 32'h1000, 0, 4, 32'h100);
    in_t B  = ins(1, 5, 7, 6, 1, 1, 0, 0, 0, 0, 2, 32'hAAAA, 32'hBBBB, 0, 32'h104);
    in_t A2 = ins(1, 1, 0, 5, 0, 1, 1, 0, 1, 1, 0, 32'h1000, 0, 4, 32'h10C);
    in_t C  = ins(1, 0, 5, 6, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 32'h110);
    in_t D  = ins(1, 2, 0, 0, 0, 1, 1, 0, 1, 1, 0, 32'h2000, 0, 8, 32'h114);
    in_t E  = ins(1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 32'h118);
    in_t F  = ins(1, 1, 0, 5, 0, 1, 1, 0, 1, 1, 0, 32'h1000, 0, 4, 32'h11C);
    in_t G  = ins(1, 5, 5, 6, 1, 1, 0, 0, 0, 0, 2, 32'h55, 32'h55, 0, 32'h120);
    in_t H  = ins(1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 2, 32'h22, 32'h33, 0, 32'h124);
    in_t X1 = ins(1, 9, 10, 11, 1, 1, 0, 1, 0, 0, 1, 32'h9, 32'hA, 32'hB, 32'h200);
    in_t X2 = ins(1, 12, 13, 14, 0, 0, 1, 0, 1, 1, 3, 32'hC, 32'hD, 32'hE, 32'h204);
    in_t I  = ins(1, 11, 12, 10, 1, 1, 0, 0, 0, 0, 3, 32'h11, 32'h12, 0, 32'h128);
    in_t J  = ins(0, 3, 4, 5, 1, 1, 1, 1, 1, 1, 3, 32'h31, 32'h41, 32'h51, 32'h12C);
    in_t K  = ins(1, 5, 0, 8, 0, 1, 0, 0, 0, 1, 0, 32'h61, 0, 32'h7, 32'h130);
    in_t M  = ins(1, 4, 0, 5, 0, 1, 1, 0, 1, 1, 0, 32'h400, 0, 32'h10, 32'h134);
    in_t N  = ins(1, 5, 5, 6, 1, 1, 0, 0, 0, 0, 2, 32'h77, 32'h77, 0, 32'h138);
    in_t O  = '0;

    drive(rnd(), 1, 1'($urandom), 0);
    step("reset",        rnd(), 1, 1'($urandom), 0, bub, 0, 1);
    step("lw_in",        A,  0, 0, 0, bub,     0, 1);
    step("load_use",     B,  0, 0, 0, cap(A),  1, 0);
    step("bubble",       B,  0, 0, 0, bub,     0, 1);
    step("dep_loaded",   A2, 0, 0, 0, cap(B),  0, 1);
    step("unused_rs2",   C,  0, 0, 0, cap(A2), 0, 1);
    step("addi_in",      D,  0, 0, 0, cap(C),  0, 1);
    step("rd0_load",     E,  0, 0, 0, cap(D),  0, 1);
    step("rd0_dep",      F,  0, 0, 0, cap(E),  0, 1);
    step("flush_hz",     G,  0, 1, 0, cap(F),  0, 1);
    step("flush_bub",    H,  0, 0, 0, bub,     0, 1);
    step("hold1",        X1, 0, 0, 1, cap(H),  0, 0);
    step("hold2",        X2, 0, 0, 1, cap(H),  0, 0);
    step("hold3",        X1, 0, 0, 1, cap(H),  0, 0);
    step("hold_rel",     I,  0, 0, 0, cap(H),  0, 1);
    step("after_hold",   J,  0, 0, 0, cap(I),  0, 1);
    step("invalid_gate", K,  0, 0, 0, cap(J),  0, 1);
    step("lw2_in",       M,  0, 0, 0, cap(K),  0, 1);
    step("both_hold",    N,  0, 0, 1, cap(M),  1, 0);
    step("both_stall",   N,  0, 0, 0, cap(M),  1, 0);
    step("both_bubble",  N,  0, 0, 0, bub,     0, 1);
    step("both_loaded",  O,  0, 0, 0, cap(N),  0, 1);
    step("lw3_in",       M,  0, 0, 0, cap(O),  0, 1);
    step("rst_stall",    N,  1, 0, 0, cap(M),  1, 0);
    step("rst_clear",    O,  0, 0, 0, bub,     0, 1);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage core, with integrated load-use hazard detection.
- Sits between decode and execute and owns every ID/EX field. Its RS1_ID_EX / RS2_ID_EX / RD_ID_EX / regwrite outputs feed the forwarding unit and the EX operand muxes.
- On a load-use dependency it stalls PC and IF/ID and injects one bubble. It also honours branch flush and external memory-wait hold.

Parameters:
- XLEN, 32, datapath width of register operands, immediate and PC.
- AW, 5, register-index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- ID_valid  in  1  decode slot holds a real instruction.
- RS1_ID  in  AW  decoded rs1 index.
- RS2_ID  in  AW  decoded rs2 index.
- RD_ID  in  AW  decoded rd index.
- uses_rs2_ID  in  1  instruction actually reads rs2 (0 for I-type/load).
- regwrite_ID, memread_ID, memwrite_ID, memtoreg_ID, alusrc_ID  in  1 each  decoded control.
- aluop_ID  in  2  ALU op class.
- rdata1_ID, rdata2_ID, imm_ID, pc_ID  in  XLEN each  register-file reads, immediate, PC.
- flush  in  1  branch/jump taken in EX; kill the instruction entering ID/EX.
- hold  in  1  downstream memory wait; freeze ID/EX.
- RS1_ID_EX, RS2_ID_EX, RD_ID_EX  out  AW each  registered indices.
- regwrite_ID_EX, memread_ID_EX, memwrite_ID_EX, memtoreg_ID_EX, alusrc_ID_EX, valid_ID_EX  out  1 each  registered control.
- aluop_ID_EX  out  2  registered ALU op.
- rdata1_ID_EX, rdata2_ID_EX, imm_ID_EX, pc_ID_EX  out  XLEN each  registered data.
- PC_write  out  1  0 = freeze PC.
- IF_ID_write  out  1  0 = freeze IF/ID.
- load_use_stall  out  1  hazard indicator (combinational).

Behaviour:
- Reset (rst=1 at edge): all registered outputs are 0, including valid_ID_EX=0 and all controls=0. Reset overrides all other inputs, even mid-stall.
- Hazard detection (combinational from current ID/EX regs and ID inputs):
  - hz = valid_ID_EX & memread_ID_EX & (RD_ID_EX!=0) & ID_valid & ((RD_ID_EX==RS1_ID) | (uses_rs2_ID & (RD_ID_EX==RS2_ID))).
  - load_use_stall = hz & ~flush.
- Freeze outputs: PC_write = IF_ID_write = ~(load_use_stall | hold).
- Register update priority per edge: rst > hold > flush > load_use_stall > normal load.
  - hold: all ID/EX fields keep their value, including any bubble. The hazard is not resolved while hold=1, so no duplicate bubble is created.
  - flush: insert bubble. A bubble means valid, regwrite, memread, memwrite, memtoreg = 0; other fields are don't-care but are cleared to 0 for determinism.
  - load_use_stall: insert bubble. The ID instruction remains in IF/ID because IF_ID_write=0. The next cycle the ID/EX entry is a bubble (memread=0), so hz drops and the instruction loads. Net penalty is exactly 1 cycle.
  - normal: capture all *_ID inputs; valid_ID_EX = ID_valid. When ID_valid=0, controls are still captured and gated to 0.
- Latency: 1 cycle from ID inputs to ID_EX outputs.
- Edge cases:
  - RD_ID_EX=0 with memread never stalls.
  - rd matching both rs1 and rs2 gives a single 1-cycle stall.
  - Back-to-back loads with a dependent third instruction stall only against the immediate predecessor. The two-ahead case is handled by forwarding.
  - flush and hazard together: flush wins and load_use_stall=0. The flushed ID instruction is discarded upstream.

Optional Feature:
- Macro: ID_EX_STALL_COUNT_EN.
- Enabled:
  - Adds output stall_cnt [31:0] and output bubble_cnt [31:0], cleared on rst.
  - stall_cnt increments each cycle load_use_stall=1 and hold=0.
  - bubble_cnt increments each cycle a bubble is written (flush or stall path).
  - Both counters saturate at 0xFFFFFFFF.
- Disabled: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: drive random inputs with rst=1 for 2 cycles -> all outputs 0, PC_write=1, IF_ID_write=1.
- Load-use: ID/EX holds lw x5 (memread=1, RD=5) and ID has add x6,x5,x7 -> load_use_stall=1 and PC_write=0 for exactly 1 cycle. The next ID/EX is a bubble (valid=0, regwrite=0); the following cycle RS1_ID_EX=5, RD_ID_EX=6, valid=1.
- Unused rs2: lw x5 in EX with addi x6,x0,5 in ID (RS2_ID=5, uses_rs2_ID=0) -> no stall. Repeat with RD_ID_EX=0 -> no stall.
- Flush vs hazard: same setup as the load-use case plus flush=1 -> load_use_stall=0, ID/EX becomes a bubble, PC_write=1.
- Hold: load add x1,x2,x3, then assert hold for 3 cycles while changing ID inputs -> ID/EX fields unchanged and PC_write=0 throughout. After release, the next ID input is captured.
- Counters (macro on): 2 load-use stalls plus 1 flush -> stall_cnt=2, bubble_cnt=3. Preload stall_cnt near max -> saturates at 0xFFFFFFFF.
